free_list: RTL and testbench

// - Physical-register free list feeding the rename stage. Supplies up to 4 new rd pregs per cycle; these index the busy table's rd port.
// - Reclaims old pregs at commit.
// - Keeps a committed head pointer so branch or exception recovery restores the speculative free list in one cycle.

---
 rtl/free_list_if.sv | 33 +++
 rtl/free_list.sv | 132 +++++++++++++
 tb/tb_free_list.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename/commit port bundle for the physical-register free list.
// The master drives requests; the slave (free_list) drives status, grants and debug pointers.
interface free_list_if #(
  parameter int PREG_W = 6,
  parameter int LANES  = 4
);
  // alloc_fire is the valid and alloc_ready is the ready: pregs are consumed only on a cycle
  // where both are high and recover_valid is low. Commit and recover need no ready; they always apply.
  logic [LANES-1:0]             alloc_req;
  logic                         alloc_fire;
  logic                         alloc_ready;
  logic [LANES-1:0][PREG_W-1:0] alloc_preg_vec;
  logic [LANES-1:0]             commit_valid;
  logic [LANES-1:0][PREG_W-1:0] commit_old_preg;
  logic                         recover_valid;
  logic [PREG_W:0]              free_count;
  logic                         dup_free_err;
  logic [PREG_W:0]              dbg_spec_head;
  logic [PREG_W:0]              dbg_cmt_head;
  logic [PREG_W:0]              dbg_tail;

  modport master (
    output alloc_req, alloc_fire, commit_valid, commit_old_preg, recover_valid,
    input  alloc_ready, alloc_preg_vec, free_count, dup_free_err,
    input  dbg_spec_head, dbg_cmt_head, dbg_tail
  );

  modport slave (
    input  alloc_req, alloc_fire, commit_valid, commit_old_preg, recover_valid,
    output alloc_ready, alloc_preg_vec, free_count, dup_free_err,
    output dbg_spec_head, dbg_cmt_head, dbg_tail
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular buffer with speculative head, committed head and tail.
// Defining FREE_LIST_DUP_CHECK_EN adds an in_list vector that drops and flags duplicate frees.
module free_list #(
  parameter int PRF_NUM  = 64,
  parameter int ARCH_NUM = 32,
  parameter int PREG_W   = 6,
  parameter int LANES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  free_list_if.slave bus
);
  typedef logic [PREG_W:0]   ptr_t;
  typedef logic [PREG_W-1:0] preg_t;

  preg_t entry_q [PRF_NUM];
  preg_t entry_d [PRF_NUM];
  ptr_t  spec_head_q, spec_head_d;
  ptr_t  cmt_head_q,  cmt_head_d;
  ptr_t  tail_q,      tail_d;
  ptr_t  free_cnt, req_cnt, cmt_cnt;
  logic  alloc_ok;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [PRF_NUM-1:0] in_list_q, in_list_d;
  logic               dup_err_q, dup_err_d;
`endif

  function automatic ptr_t popcnt(input logic [LANES-1:0] v);
    ptr_t c;
    c = '0;
    for (int l = 0; l < LANES; l++) c = c + ptr_t'(v[l]);
    return c;
  endfunction

  assign free_cnt          = tail_q - spec_head_q;
  assign req_cnt           = popcnt(bus.alloc_req);
  assign cmt_cnt           = popcnt(bus.commit_valid);
  assign bus.free_count    = free_cnt;
  assign bus.alloc_ready   = (free_cnt >= req_cnt);
  assign alloc_ok          = bus.alloc_fire && bus.alloc_ready && !bus.recover_valid;
  assign bus.dbg_spec_head = spec_head_q;
  assign bus.dbg_cmt_head  = cmt_head_q;
  assign bus.dbg_tail      = tail_q;

  // Requesting lanes take consecutive entries from spec_head in ascending lane order.
  always_comb begin : alloc_read
    ptr_t k;
    k = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.alloc_preg_vec[l] = '0;
      if (bus.alloc_req[l]) begin
        bus.alloc_preg_vec[l] = entry_q[preg_t'(spec_head_q + k)];
        k = k + ptr_t'(1);
      end
    end
  end

  always_comb begin : head_next
    cmt_head_d  = cmt_head_q + cmt_cnt;
    spec_head_d = spec_head_q;
    if (bus.recover_valid) spec_head_d = cmt_head_d;
    else if (alloc_ok)     spec_head_d = spec_head_q + req_cnt;
  end

  always_comb begin : commit_write
    ptr_t wp;
    logic wr_en;
    entry_d = entry_q;
    wp      = tail_q;
    wr_en   = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
    in_list_d = in_list_q;
    dup_err_d = dup_err_q;
    if (alloc_ok) begin
      for (int l = 0; l < LANES; l++)
        if (bus.alloc_req[l]) in_list_d[bus.alloc_preg_vec[l]] = 1'b0;
    end
    // Entries between the restored head and the old speculative head return to the list.
    if (bus.recover_valid) begin
      for (int i = 0; i < PRF_NUM; i++)
        if (ptr_t'(preg_t'(i) - spec_head_d[PREG_W-1:0]) < (spec_head_q - spec_head_d))
          in_list_d[entry_q[i]] = 1'b1;
    end
`endif
    for (int l = 0; l < LANES; l++) begin
      wr_en = bus.commit_valid[l] && (bus.commit_old_preg[l] != '0);
`ifdef FREE_LIST_DUP_CHECK_EN
      if (wr_en && in_list_d[bus.commit_old_preg[l]]) begin
        wr_en     = 1'b0;
        dup_err_d = 1'b1;
      end
      if (wr_en) in_list_d[bus.commit_old_preg[l]] = 1'b1;
`endif
      if (wr_en) begin
        entry_d[wp[PREG_W-1:0]] = bus.commit_old_preg[l];
        wp = wp + ptr_t'(1);
      end
    end
    tail_d = wp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PRF_NUM; i++)
        entry_q[i] <= (i < PRF_NUM - ARCH_NUM) ? preg_t'(ARCH_NUM + i) : preg_t'(0);
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= ptr_t'(PRF_NUM - ARCH_NUM);
    end else begin
      entry_q     <= entry_d;
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PRF_NUM; i++) in_list_q[i] <= (i >= ARCH_NUM);
      dup_err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_err_q <= dup_err_d;
    end
  end
  assign bus.dup_free_err = dup_err_q;
`else
  assign bus.dup_free_err = 1'b0;
`endif
endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: reset/alloc/commit/recover vector table, hand sequences for the
// drain, recover, duplicate-free and mid-burst reset cases, then a randomized queue model.
module tb_free_list;
  localparam int PREG_W = 6;
  localparam int LANES  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  free_list_if #(.PREG_W(PREG_W), .LANES(LANES)) bus ();

  free_list #(.PRF_NUM(64), .ARCH_NUM(32), .PREG_W(PREG_W), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]       req;
    logic             fire;
    logic [3:0]       cv;
    logic [3:0][5:0]  old;
    logic             rec;
    logic             exp_ready;
    logic [6:0]       exp_cnt;
    logic [3:0][5:0]  exp_vec;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req       = '0;
    bus.alloc_fire      = 1'b0;
    bus.commit_valid    = '0;
    bus.commit_old_preg = '0;
    bus.recover_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    tbl[0] = '{req:4'h0, fire:1'b0, cv:4'h0, old:'0, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd32, exp_vec:'0};
    tbl[1] = '{req:4'hF, fire:1'b1, cv:4'h0, old:'0, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd32, exp_vec:{6'd35, 6'd34, 6'd33, 6'd32}};
    tbl[2] = '{req:4'b1010, fire:1'b1, cv:4'h0, old:'0, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd28, exp_vec:{6'd37, 6'd0, 6'd36, 6'd0}};
    tbl[3] = '{req:4'b0001, fire:1'b0, cv:4'b0011, old:{6'd0, 6'd0, 6'd7, 6'd5}, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd26, exp_vec:{6'd0, 6'd0, 6'd0, 6'd38}};
    tbl[4] = '{req:4'h0, fire:1'b1, cv:4'h0, old:'0, rec:1'b1,
               exp_ready:1'b1, exp_cnt:7'd28, exp_vec:'0};
    tbl[5] = '{req:4'hF, fire:1'b1, cv:4'h0, old:'0, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd32, exp_vec:{6'd37, 6'd36, 6'd35, 6'd34}};
    tbl[6] = '{req:4'h0, fire:1'b0, cv:4'h0, old:'0, rec:1'b0,
               exp_ready:1'b1, exp_cnt:7'd28, exp_vec:'0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.alloc_req       = tbl[i].req;
      bus.alloc_fire      = tbl[i].fire;
      bus.commit_valid    = tbl[i].cv;
      bus.commit_old_preg = tbl[i].old;
      bus.recover_valid   = tbl[i].rec;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), bus.alloc_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_count", i), bus.free_count, tbl[i].exp_cnt);
      for (int l = 0; l < LANES; l++)
        chk($sformatf("tbl%0d_lane%0d", i, l), bus.alloc_preg_vec[l], tbl[i].exp_vec[l]);
      tick();
    end
    idle();
  endtask

  task automatic seq_drain();
    do_reset();
    bus.alloc_req  = 4'hF;
    bus.alloc_fire = 1'b1;
    repeat (7) tick();
    bus.alloc_req = 4'b0011;
    tick();
    bus.alloc_req = 4'b0111;
    @(negedge clk);
    chk("drain_count", bus.free_count, 2);
    chk("drain_not_ready", bus.alloc_ready, 0);
    tick();
    bus.alloc_fire      = 1'b0;
    bus.commit_valid    = 4'b0011;
    bus.commit_old_preg = {6'd0, 6'd0, 6'd7, 6'd5};
    @(negedge clk);
    chk("drain_head_held", bus.dbg_spec_head, 30);
    chk("drain_precommit_ready", bus.alloc_ready, 0);
    tick();
    bus.commit_valid = '0;
    @(negedge clk);
    chk("drain_refill_count", bus.free_count, 4);
    chk("drain_refill_ready", bus.alloc_ready, 1);
    idle();
  endtask

  task automatic seq_recover();
    do_reset();
    bus.alloc_req  = 4'hF;
    bus.alloc_fire = 1'b1;
    repeat (3) tick();
    idle();
    bus.commit_valid    = 4'hF;
    bus.commit_old_preg = {6'd4, 6'd3, 6'd2, 6'd1};
    tick();
    idle();
    bus.recover_valid = 1'b1;
    bus.alloc_req     = 4'hF;
    bus.alloc_fire    = 1'b1;
    tick();
    idle();
    bus.alloc_req = 4'b0001;
    @(negedge clk);
    chk("rec_spec_head", bus.dbg_spec_head, 4);
    chk("rec_cmt_head", bus.dbg_cmt_head, 4);
    chk("rec_count", bus.free_count, 32);
    chk("rec_next_alloc", bus.alloc_preg_vec[0], 36);
    idle();
  endtask

  task automatic seq_dup_and_reset();
    do_reset();
    bus.commit_valid    = 4'b0011;
    bus.commit_old_preg = {6'd0, 6'd0, 6'd9, 6'd9};
    tick();
    idle();
    @(negedge clk);
`ifdef FREE_LIST_DUP_CHECK_EN
    chk("dup_count", bus.free_count, 33);
    chk("dup_err", bus.dup_free_err, 1);
    chk("dup_tail", bus.dbg_tail, 33);
`else
    chk("dup_count", bus.free_count, 34);
    chk("dup_err", bus.dup_free_err, 0);
    chk("dup_tail", bus.dbg_tail, 34);
`endif
    bus.alloc_req       = 4'hF;
    bus.alloc_fire      = 1'b1;
    bus.commit_valid    = 4'hF;
    bus.commit_old_preg = {6'd4, 6'd3, 6'd2, 6'd1};
    bus.recover_valid   = 1'b1;
    tick();
    bus.recover_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_count", bus.free_count, 32);
    chk("rst_ready", bus.alloc_ready, 1);
    chk("rst_spec_head", bus.dbg_spec_head, 0);
    chk("rst_cmt_head", bus.dbg_cmt_head, 0);
    chk("rst_tail", bus.dbg_tail, 32);
    chk("rst_dup_err", bus.dup_free_err, 0);
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  // Free list as a queue of pregs, in-flight allocations as a queue, mapped pregs as a pool.
  task automatic run_random(input int cycles);
    int   free_q[$];
    int   infl_q[$];
    int   pool_q[$];
    int   tail_total;
    logic err_exp;
    bit   saw_wrap;
    do_reset();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
    for (int i = 1; i < 32; i++) pool_q.push_back(i);
    tail_total = 32;
    err_exp    = 1'b0;
    saw_wrap   = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      logic [3:0] req, mask;
      logic       fire, rec;
      int         olds[4];
      int         n, k, idx;
      bit         acc, found;
      req  = 4'($urandom_range(0, 15));
      fire = ($urandom_range(0, 3) != 0);
      rec  = ($urandom_range(0, 15) == 0);
      mask = 4'($urandom_range(0, 15));
      while ($countones(mask) > infl_q.size()) mask = mask & (mask - 4'd1);
      for (int l = 0; l < LANES; l++) begin
        olds[l] = 0;
        if (mask[l] && $urandom_range(0, 7) != 0) begin
          idx     = $urandom_range(0, pool_q.size() - 1);
          olds[l] = pool_q[idx];
          pool_q.delete(idx);
        end
        bus.commit_old_preg[l] = 6'(olds[l]);
      end
      bus.alloc_req     = req;
      bus.alloc_fire    = fire;
      bus.commit_valid  = mask;
      bus.recover_valid = rec;
      @(negedge clk);
      n = $countones(req);
      chk("rnd_ready", bus.alloc_ready, int'(free_q.size() >= n));
      chk("rnd_count", bus.free_count, free_q.size());
      chk("rnd_tail", bus.dbg_tail, tail_total % 128);
      chk("rnd_dup_err", bus.dup_free_err, err_exp);
      if (free_q.size() >= n) begin
        k = 0;
        for (int l = 0; l < LANES; l++) begin
          if (req[l]) begin
            chk($sformatf("rnd_lane%0d", l), bus.alloc_preg_vec[l], free_q[k]);
            k++;
          end else begin
            chk($sformatf("rnd_lane%0d_idle", l), bus.alloc_preg_vec[l], 0);
          end
        end
      end
      acc = fire && !rec && (free_q.size() >= n);
      if (acc) begin
        for (int l = 0; l < LANES; l++) begin
          if (req[l]) begin
            chk("rnd_no_preg0", int'(bus.alloc_preg_vec[l] != 6'd0), 1);
            infl_q.push_back(free_q.pop_front());
          end
        end
      end
      for (int l = 0; l < LANES; l++)
        if (mask[l]) pool_q.push_back(infl_q.pop_front());
      if (rec) begin
        for (int j = infl_q.size() - 1; j >= 0; j--) free_q.push_front(infl_q[j]);
        infl_q.delete();
      end
      for (int l = 0; l < LANES; l++) begin
        if (mask[l] && olds[l] != 0) begin
          found = 1'b0;
          for (int j = 0; j < free_q.size(); j++) if (free_q[j] == olds[l]) found = 1'b1;
`ifdef FREE_LIST_DUP_CHECK_EN
          if (found) err_exp = 1'b1;
          else begin
            free_q.push_back(olds[l]);
            tail_total++;
          end
`else
          free_q.push_back(olds[l]);
          tail_total++;
`endif
        end
      end
      tick();
      if (bus.dbg_tail[PREG_W]) saw_wrap = 1'b1;
    end
    idle();
    @(negedge clk);
    chk("rnd_final_count", bus.free_count, free_q.size());
    chk("rnd_ptr_wrapped", saw_wrap, 1);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", bus.free_count, 32);
    chk("reset_ready", bus.alloc_ready, 1);
    chk("reset_dup_err", bus.dup_free_err, 0);
    chk("reset_tail", bus.dbg_tail, 32);
    run_table();
    seq_drain();
    seq_recover();
    seq_dup_and_reset();
    run_random(200);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
